port_master: RTL and testbench

- Initiator side of the CPU port I/O bus: turns IN/OUT requests from the CPU execution unit into single-cycle port_clk strobes that the port responders decode.
- Word accesses (IN AX / OUT DX,AX) are split into two byte transactions, low byte at port, high byte at port+1, little-endian.
- Read data is sampled from the responder's registered port_i and returned with a one-cycle rsp_valid pulse.

---
 rtl/port_master.sv | 192 +++++++++++++++++++
 tb/tb_port_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_master.sv
// Initiator side of the CPU port I/O bus.
// Turns IN/OUT requests into single-cycle port_clk strobes. Word accesses are split
// into two byte transactions (low byte at port, high byte at port+1). Read data is
// sampled from the responder after WAIT_CYCLES cycles and returned with a rsp_valid pulse.
module port_master #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_word,
    input  logic        req_write,
    input  logic [15:0] req_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        port_clk,
    output logic [15:0] port,
    output logic [7:0]  port_o,
    output logic        port_w,
    input  logic [7:0]  port_i
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] STB0  = 3'd1;
    localparam logic [2:0] WAIT0 = 3'd2;
    localparam logic [2:0] STB1  = 3'd3;
    localparam logic [2:0] WAIT1 = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    // Wait counter runs WAIT_CYCLES-1 down to 0; capture happens on the edge ending the 0 cycle.
    localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        word_q, word_d;
    logic        write_q, write_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  lo_q, lo_d;

    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        port_clk_q, port_clk_d;
    logic [15:0] port_q, port_d;
    logic [7:0]  port_o_q, port_o_d;
    logic        port_w_q, port_w_d;

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign port_clk  = port_clk_q;
    assign port      = port_q;
    assign port_o    = port_o_q;
    assign port_w    = port_w_q;

    // Next state and next registered outputs; outputs are computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        word_d      = word_q;
        write_d     = write_q;
        data_d      = data_q;
        lo_d        = lo_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        port_clk_d  = 1'b0;
        port_d      = port_q;
        port_o_d    = port_o_q;
        port_w_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    word_d     = req_word;
                    write_d    = req_write;
                    data_d     = req_data;
                    state_d    = STB0;
                    port_clk_d = 1'b1;
                    port_d     = req_addr;
                    port_o_d   = req_data[7:0];
                    port_w_d   = req_write;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            STB0: begin
                if (!write_q) begin
                    state_d = WAIT0;
                    cnt_d   = RELOAD;
                end else if (word_q) begin
                    // Write halves go out on consecutive cycles with distinct addresses.
                    state_d    = STB1;
                    port_clk_d = 1'b1;
                    port_d     = addr_q + 16'd1;
                    port_o_d   = data_q[15:8];
                    port_w_d   = 1'b1;
                end else begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 16'h0000;
                end
            end
            WAIT0: begin
                if (cnt_q == 4'd0) begin
                    lo_d = port_i;
                    if (word_q) begin
                        state_d    = STB1;
                        port_clk_d = 1'b1;
                        port_d     = addr_q + 16'd1;
                        port_o_d   = data_q[15:8];
                        port_w_d   = write_q;
                    end else begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = {8'h00, port_i};
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STB1: begin
                if (!write_q) begin
                    state_d = WAIT1;
                    cnt_d   = RELOAD;
                end else begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 16'h0000;
                end
            end
            WAIT1: begin
                if (cnt_q == 4'd0) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = {port_i, lo_q};
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 16'h0000;
            word_q      <= 1'b0;
            write_q     <= 1'b0;
            data_q      <= 16'h0000;
            lo_q        <= 8'h00;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            port_clk_q  <= 1'b0;
            port_q      <= 16'h0000;
            port_o_q    <= 8'h00;
            port_w_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            write_q     <= write_d;
            data_q      <= data_d;
            lo_q        <= lo_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            port_clk_q  <= port_clk_d;
            port_q      <= port_d;
            port_o_q    <= port_o_d;
            port_w_q    <= port_w_d;
        end
    end

endmodule

// File: tb/tb_port_master.sv
// Bench for port_master: two instances (WAIT_CYCLES=1 and 3) sharing request lines,
// each with a responder model; expected strobes and responses go through scoreboards.
module tb_port_master;

    typedef struct {
        logic [15:0] port;
        logic [7:0]  dat;
        logic        w;
    } stb_t;

    typedef struct {
        logic [15:0] data;
        int          lat;
    } rsp_t;

    logic        clock;
    logic        reset_n;
    logic [15:0] req_addr;
    logic        req_word;
    logic        req_write;
    logic [15:0] req_data;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [15:0] rsp_data  [2];
    logic        port_clk  [2];
    logic [15:0] port      [2];
    logic [7:0]  port_o    [2];
    logic        port_w    [2];
    logic [7:0]  port_i    [2];

    stb_t stb_q [2][$];
    rsp_t rsp_q [2][$];
    int   acc_q [2][$];
    int   rsp_cnt [2];

    int cyc;
    int n_total;
    int n_bad;

    port_master #(.WAIT_CYCLES(1)) u_dut0 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr), .req_word(req_word), .req_write(req_write), .req_data(req_data),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
        .port_clk(port_clk[0]), .port(port[0]), .port_o(port_o[0]), .port_w(port_w[0]),
        .port_i(port_i[0])
    );

    port_master #(.WAIT_CYCLES(3)) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr), .req_word(req_word), .req_write(req_write), .req_data(req_data),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
        .port_clk(port_clk[1]), .port(port[1]), .port_o(port_o[1]), .port_w(port_w[1]),
        .port_i(port_i[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Responder byte contents for reads.
    function automatic logic [7:0] model(input logic [15:0] a);
        if (a == 16'h0060) return 8'h34;
        if (a == 16'h0061) return 8'h12;
        return a[7:0] ^ {a[14:8], a[15]} ^ 8'h5A;
    endfunction

    // Responders register port_i on a read strobe edge.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++)
            if (port_clk[k] && !port_w[k]) port_i[k] <= model(port[k]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor, sampling at the falling edge.
    always @(negedge clock) begin
        stb_t s;
        rsp_t e;
        int   a;
        if (reset_n) begin
            for (int k = 0; k < 2; k++) begin
                if (req_valid[k] && req_ready[k]) acc_q[k].push_back(cyc + 1);
                if (port_clk[k]) begin
                    if (stb_q[k].size() == 0) begin
                        check("stb_unexpected", 1, 0);
                    end else begin
                        s = stb_q[k].pop_front();
                        check("stb_port", port[k], s.port);
                        check("stb_port_o", port_o[k], s.dat);
                        check("stb_port_w", port_w[k], s.w);
                    end
                end else begin
                    check("port_w_idle", port_w[k], 0);
                end
                if (rsp_valid[k]) begin
                    rsp_cnt[k]++;
                    if (rsp_q[k].size() == 0) begin
                        check("rsp_unexpected", 1, 0);
                    end else begin
                        e = rsp_q[k].pop_front();
                        a = (acc_q[k].size() != 0) ? acc_q[k].pop_front() : cyc + 1;
                        check("rsp_data", rsp_data[k], e.data);
                        check("rsp_latency", (cyc + 1) - a, e.lat);
                    end
                end
            end
        end
    end

    task automatic push_expect(input int k, input logic [15:0] a, input logic wd,
                               input logic wr, input logic [15:0] d);
        stb_t s;
        rsp_t r;
        int   w;
        w = (k == 0) ? 1 : 3;
        s.port = a; s.dat = d[7:0]; s.w = wr;
        stb_q[k].push_back(s);
        if (wd) begin
            s.port = a + 16'd1; s.dat = d[15:8]; s.w = wr;
            stb_q[k].push_back(s);
        end
        if (wr) begin
            r.data = 16'h0000;
            r.lat  = wd ? 3 : 2;
        end else begin
            r.data = wd ? {model(a + 16'd1), model(a)} : {8'h00, model(a)};
            r.lat  = wd ? 3 + 2 * w : 2 + w;
        end
        rsp_q[k].push_back(r);
    endtask

    // Called just after a posedge; returns just after the accept edge.
    task automatic send(input int k, input logic [15:0] a, input logic wd,
                        input logic wr, input logic [15:0] d);
        int i;
        push_expect(k, a, wd, wr, d);
        req_addr = a; req_word = wd; req_write = wr; req_data = d;
        req_valid[k] = 1'b1;
        for (i = 0; i < 100; i++) begin
            @(negedge clock);
            if (req_ready[k]) break;
        end
        if (i == 100) check("accept_timeout", 0, 1);
        @(posedge clock);
        #1 req_valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        for (int i = 0; i < 200 && rsp_q[k].size() != 0; i++) @(negedge clock);
        check("drain", rsp_q[k].size(), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset(input int k);
        check("rst_req_ready", req_ready[k], 1);
        check("rst_rsp_valid", rsp_valid[k], 0);
        check("rst_rsp_data", rsp_data[k], 0);
        check("rst_port_clk", port_clk[k], 0);
        check("rst_port", port[k], 0);
        check("rst_port_o", port_o[k], 0);
        check("rst_port_w", port_w[k], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_acc, b_acc, busy, n_rsp;
        stb_t s;
        cyc = 0; n_total = 0; n_bad = 0;
        rsp_cnt[0] = 0; rsp_cnt[1] = 0;
        reset_n = 1'b0;
        req_addr = '0; req_word = 1'b0; req_write = 1'b0; req_data = '0;
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        repeat (3) @(posedge clock);
        #1 check_reset(0);
        check_reset(1);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Directed transactions.
        send(0, 16'h03D4, 1'b0, 1'b1, 16'h000E);
        wait_idle(0);
        send(0, 16'h03D4, 1'b1, 1'b1, 16'h0F0E);
        wait_idle(0);
        send(0, 16'h0060, 1'b1, 1'b0, 16'h0000);
        wait_idle(0);
        send(1, 16'hFFFF, 1'b0, 1'b0, 16'h00AA);
        wait_idle(1);
        send(1, 16'hFFFF, 1'b1, 1'b0, 16'h5555);
        wait_idle(1);
        send(0, 16'hFFFF, 1'b1, 1'b1, 16'hA55A);
        wait_idle(0);

        // Back-to-back random traffic on both instances.
        for (int i = 0; i < 12; i++)
            send(i % 2, 16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
        wait_idle(0);
        wait_idle(1);

        // Busy rejection: request held valid with changing inputs during a word write.
        push_expect(0, 16'h0100, 1'b1, 1'b1, 16'hBEEF);
        push_expect(0, 16'h0200, 1'b0, 1'b1, 16'h1357);
        req_addr = 16'h0100; req_word = 1'b1; req_write = 1'b1; req_data = 16'hBEEF;
        req_valid[0] = 1'b1;
        @(negedge clock);
        check("busy_first_ready", req_ready[0], 1);
        @(posedge clock);
        #1 a_acc = cyc;
        busy = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (req_ready[0]) break;
            busy++;
            if (busy <= 2) begin
                req_data = 16'($urandom);
                req_addr = 16'($urandom);
            end else begin
                req_addr = 16'h0200; req_word = 1'b0; req_write = 1'b1; req_data = 16'h1357;
            end
        end
        @(posedge clock);
        #1 b_acc = cyc;
        req_valid[0] = 1'b0;
        check("busy_accept_gap", b_acc - a_acc, 4);
        wait_idle(0);

        // Reset during WAIT0 of a word read.
        s.port = 16'h0060; s.dat = 8'h00; s.w = 1'b0;
        stb_q[0].push_back(s);
        req_addr = 16'h0060; req_word = 1'b1; req_write = 1'b0; req_data = 16'h0000;
        req_valid[0] = 1'b1;
        @(negedge clock);
        @(posedge clock);
        #1 req_valid[0] = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 check_reset(0);
        check_reset(1);
        check("rst_first_strobe_seen", stb_q[0].size(), 0);
        for (int k = 0; k < 2; k++) begin
            stb_q[k].delete();
            rsp_q[k].delete();
            acc_q[k].delete();
        end
        n_rsp = rsp_cnt[0];
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        check("no_rsp_after_reset", rsp_cnt[0], n_rsp);
        @(posedge clock);
        #1;
        send(0, 16'h0060, 1'b1, 1'b0, 16'h0000);
        wait_idle(0);
        send(1, 16'h0061, 1'b0, 1'b0, 16'h0000);
        wait_idle(1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
